// File: rtl/tap_byte_driver.sv
// tap_byte_driver: serializes each accepted payload word as one DR scan.
// Each scan drives Capture-DR, N Shift-DR cycles with the payload LSB first
// followed by the upstream BYPASS pad zeros, then Update-DR, then an optional
// Run-Test/Idle gap. All outputs are registered except byte_ready.
// Optional build macro: TAP_BYTE_DRIVER_STATS_EN adds the frames_sent and
// last_byte outputs.
module tap_byte_driver #(
    parameter int OUTBOUND_DATA_WIDTH  = 8,
    parameter int UPSTREAM_BYPASS_BITS = 1,
    parameter int IDLE_CYCLES          = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           byte_valid,
    input  logic [OUTBOUND_DATA_WIDTH-1:0] byte_data,
    output logic                           byte_ready,
    output logic                           tdi,
    output logic                           capture_dr,
    output logic                           shift_dr,
    output logic                           update_dr,
    output logic                           run_test_idle,
    output logic                           busy
`ifdef TAP_BYTE_DRIVER_STATS_EN
    ,
    output logic [15:0]                    frames_sent,
    output logic [OUTBOUND_DATA_WIDTH-1:0] last_byte
`endif
);

    localparam int N     = OUTBOUND_DATA_WIDTH + UPSTREAM_BYPASS_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(N);
    // GAP counts down from IDLE_CYCLES-1 to 0, one cycle per count
    localparam logic [7:0] GAP_LOAD = 8'((IDLE_CYCLES > 0) ? (IDLE_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        UPDATE,
        GAP
    } state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     shreg_reg, shreg_next;
    logic [N-1:0]     shreg_shifted;
    logic [N-1:0]     shreg_load;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0]       gap_cnt_reg, gap_cnt_next;
    logic             tdi_reg, tdi_next;
    logic             capture_reg, capture_next;
    logic             shift_reg, shift_next;
    logic             update_reg, update_next;
    logic             rti_reg, rti_next;
    logic             busy_reg, busy_next;
    logic             accept;

    // Ready is the only combinational output; reset masks it so a request
    // arriving together with reset is never accepted.
    assign byte_ready = (state_reg == IDLE) && !reset;
    assign accept     = byte_valid && byte_ready;

    // Shift-right-by-one with zero fill, and the payload load image with the
    // pad bits above the payload held at zero.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_shreg
            if (gi == N - 1) begin : g_top
                assign shreg_shifted[gi] = 1'b0;
            end else begin : g_mid
                assign shreg_shifted[gi] = shreg_reg[gi+1];
            end
            if (gi < OUTBOUND_DATA_WIDTH) begin : g_data
                assign shreg_load[gi] = byte_data[gi];
            end else begin : g_pad
                assign shreg_load[gi] = 1'b0;
            end
        end
    endgenerate

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        tdi_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    shreg_next   = shreg_load;
                    bit_cnt_next = BIT_LOAD;
                    state_next   = CAPTURE;
                end
            end
            CAPTURE: state_next = SHIFT;
            SHIFT: begin
                if (bit_cnt_reg == '0) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                if (IDLE_CYCLES > 0) begin
                    state_next   = GAP;
                    gap_cnt_next = GAP_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_reg == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Every cycle spent in SHIFT presents one bit and consumes one count.
        if (state_next == SHIFT) begin
            tdi_next     = shreg_reg[0];
            shreg_next   = shreg_shifted;
            bit_cnt_next = bit_cnt_reg - 1'b1;
        end

        capture_next = (state_next == CAPTURE);
        shift_next   = (state_next == SHIFT);
        update_next  = (state_next == UPDATE);
        rti_next     = (state_next == IDLE) || (state_next == GAP);
        busy_next    = (state_next != IDLE);
    end

    // State and registered outputs; reset aborts any scan in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= 8'd0;
            tdi_reg     <= 1'b0;
            capture_reg <= 1'b0;
            shift_reg   <= 1'b0;
            update_reg  <= 1'b0;
            rti_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            tdi_reg     <= tdi_next;
            capture_reg <= capture_next;
            shift_reg   <= shift_next;
            update_reg  <= update_next;
            rti_reg     <= rti_next;
            busy_reg    <= busy_next;
        end
    end

    assign tdi           = tdi_reg;
    assign capture_dr    = capture_reg;
    assign shift_dr      = shift_reg;
    assign update_dr     = update_reg;
    assign run_test_idle = rti_reg;
    assign busy          = busy_reg;

`ifdef TAP_BYTE_DRIVER_STATS_EN
    logic [15:0]                    frames_sent_reg;
    logic [OUTBOUND_DATA_WIDTH-1:0] last_byte_reg;
    logic [OUTBOUND_DATA_WIDTH-1:0] payload_reg;

    // Scan statistics: the shift register is consumed while shifting, so the
    // payload is kept separately until its scan completes in UPDATE.
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_sent_reg <= 16'd0;
            last_byte_reg   <= '0;
            payload_reg     <= '0;
        end else begin
            if (accept) begin
                payload_reg <= byte_data;
            end
            if (state_reg == UPDATE) begin
                frames_sent_reg <= frames_sent_reg + 16'd1;
                last_byte_reg   <= payload_reg;
            end
        end
    end

    assign frames_sent = frames_sent_reg;
    assign last_byte   = last_byte_reg;
`endif

endmodule

// File: doc/tap_byte_driver.md
# tap_byte_driver

- Transmit-side counterpart of `tap_decoder`: accepts bytes over a valid/ready handshake and serializes each as one DR scan, driving `tdi` plus the `capture_dr`/`shift_dr`/`update_dr`/`run_test_idle` strobes.
- Sits in the loopback/self-test path and in benches.
- Feeds the same TAP-state interface `tap_decoder` consumes, so upstream BYPASS padding is included in every scan.
- All outputs are registered; no combinational path from inputs to outputs except `byte_ready`.

## Interface
Parameters:
- `OUTBOUND_DATA_WIDTH`, 8: payload bits per scan.
- `UPSTREAM_BYPASS_BITS`, 1: zero pad bits appended after payload (BYPASS registers in chain).
- `IDLE_CYCLES`, 2: Run-Test/Idle cycles after each update; range 0..255.

Ports:
- `clk` in 1: single clock (TCK domain); one clock; all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `byte_valid` in 1: payload offered.
- `byte_data` in OUTBOUND_DATA_WIDTH: payload, sent LSB first.
- `byte_ready` out 1: high only in IDLE (and not in reset).
- `tdi` out 1: serial data.
- `capture_dr` out 1: Capture-DR strobe.
- `shift_dr` out 1: Shift-DR qualifier.
- `update_dr` out 1: Update-DR strobe.
- `run_test_idle` out 1: Run-Test/Idle qualifier.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, GAP.
- IDLE: `byte_ready`=1, `run_test_idle`=1. On `byte_valid && byte_ready`:
  - latch the shift register as {UPSTREAM_BYPASS_BITS zeros, byte_data};
  - load bit counter with N = OUTBOUND_DATA_WIDTH+UPSTREAM_BYPASS_BITS;
  - go to CAPTURE.
- CAPTURE: one cycle, `capture_dr`=1, then SHIFT.
- SHIFT: N cycles, `shift_dr`=1.
  - `tdi` = shift register bit 0; shift right one bit per cycle with zero fill.
  - Counter decrements each cycle; at terminal count go to UPDATE.
- UPDATE: one cycle, `update_dr`=1, `tdi`=0.
  - Then GAP if IDLE_CYCLES>0, else IDLE.
- GAP: IDLE_CYCLES cycles, `run_test_idle`=1, then IDLE.
- `byte_data` is sampled only on the accept cycle; later changes are ignored.
- Counter width = $clog2(N+1); an 8-bit gap counter.
- Exactly one of capture/shift/update/run_test_idle is high in any cycle, except during reset, when all are 0.

## Timing
- Reset values:
  - `tdi`, `capture_dr`, `shift_dr`, `update_dr`, `busy` = 0.
  - `run_test_idle` = 0 while `reset` is asserted; 1 from the first cycle after release.
  - `byte_ready` = 0 while `reset` is asserted.
- Accept at edge k:
  - `capture_dr` high in cycle k+1;
  - `shift_dr` high in cycles k+2..k+1+N, with payload bit i on `tdi` in cycle k+2+i;
  - `update_dr` high in cycle k+2+N;
  - IDLE (`byte_ready`) again at cycle k+3+N+IDLE_CYCLES.
- Throughput: one byte per N+3+IDLE_CYCLES cycles (defaults: 14).
- `byte_valid` held high through a scan: the next byte is accepted on the first IDLE cycle, so back-to-back scans need no bubble beyond that cycle.
- Reset mid-scan aborts immediately:
  - next cycle is IDLE-after-reset with all strobes 0;
  - no partial `update_dr` is issued;
  - the in-flight byte is dropped.
- Reset and `byte_valid` in the same cycle: reset wins, nothing is accepted.

## Configuration
- `TAP_BYTE_DRIVER_STATS_EN` defined:
  - adds output `frames_sent` (16 bits), reset to 0;
  - increments on every UPDATE cycle and wraps 0xFFFF→0;
  - adds output `last_byte` (OUTBOUND_DATA_WIDTH bits), the payload of the last completed scan, reset to 0.
- Macro undefined: neither port nor register exists; scan behaviour is identical.

## Test plan
- Reset release, then 0x41 offered with defaults:
  - `capture_dr` one cycle after accept;
  - 9 `shift_dr` cycles with `tdi` = 1,0,0,0,0,0,1,0,0;
  - `update_dr` once, then 2 `run_test_idle` cycles, then `byte_ready`=1.
- Stream "abcdef" with `byte_valid` held high:
  - 6 scans at exactly 14-cycle spacing;
  - a `tap_decoder` looped back emits 0x61..0x66 in order with no alignment error.
- Reset asserted in the 4th `shift_dr` cycle of 0xFF:
  - all strobes 0 the next cycle, and no `update_dr` follows;
  - the next byte 0x00 is scanned cleanly.
- `byte_data` changed from 0x12 to 0x34 during SHIFT: `tdi` still carries 0x12.
- IDLE_CYCLES=0, UPSTREAM_BYPASS_BITS=0: 11-cycle period; UPDATE goes directly to IDLE.
- STATS_EN build:
  - after 3 scans of 0x10, 0x20, 0x30: `frames_sent`=3, `last_byte`=0x30;
  - preloaded 0xFFFF wraps to 0 after one scan.
